// File: rtl/pipeline_buffer_chain.sv
// Chain of STAGES valid-qualified pipeline slots with stall/bubble handling,
// per-slot flush, snoop outputs and saturating performance counters.
module pipeline_buffer_chain #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    STAGES        = 4,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE  = '0,
    parameter int                    COUNTER_WIDTH = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           in_ready,
    input  logic [STAGES-1:0]              stall_request,
    input  logic [STAGES-1:0]              flush,
    input  logic                           counter_clear,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [STAGES-1:0]              slot_valid,
    output logic [STAGES*DATA_WIDTH-1:0]   slot_data,
    output logic [COUNTER_WIDTH-1:0]       stall_cycles,
    output logic [COUNTER_WIDTH-1:0]       bubble_count,
    output logic [COUNTER_WIDTH-1:0]       retired_count
);

    logic [STAGES-1:0]        w_hold;
    logic                     w_bubble;
    logic                     w_retire;
    logic [STAGES-1:0]        r_valid;
    logic [DATA_WIDTH-1:0]    r_data [STAGES];
    logic [COUNTER_WIDTH-1:0] r_stall_cycles;
    logic [COUNTER_WIDTH-1:0] r_bubble_count;
    logic [COUNTER_WIDTH-1:0] r_retired_count;

    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    // A stall anywhere downstream freezes every upstream slot.
    always_comb begin : hold_chain
        logic acc;
        // NOTE: every always_comb output gets a default before any conditional logic, so no latch is inferred.
        w_hold = '0;
        acc    = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc       = acc | stall_request[i];
            w_hold[i] = acc;
        end
    end

    // Hold is a prefix, so at most one slot sits at the hold boundary; a flushed one is not a bubble.
    always_comb begin
        w_bubble = 1'b0;
        for (int i = 1; i < STAGES; i++) begin
            if (w_hold[i-1] && !w_hold[i] && !flush[i]) begin
                w_bubble = 1'b1;
            end
        end
    end

    assign w_retire = r_valid[STAGES-1] && !w_hold[STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            // NOTE: the payload array is reset too, because slot_data exposes every slot to forwarding logic.
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= BUBBLE_VALUE;
            end
        end else begin
            // NOTE: non-blocking assignments let each slot capture its upstream neighbour's pre-edge value.
            if (flush[0]) begin
                r_valid[0] <= 1'b0;
                r_data[0]  <= BUBBLE_VALUE;
            end else if (!w_hold[0]) begin
                r_valid[0] <= in_valid;
                r_data[0]  <= in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (flush[i]) begin
                    r_valid[i] <= 1'b0;
                    r_data[i]  <= BUBBLE_VALUE;
                end else if (!w_hold[i]) begin
                    if (w_hold[i-1]) begin
                        r_valid[i] <= 1'b0;
                        r_data[i]  <= BUBBLE_VALUE;
                    end else begin
                        r_valid[i] <= r_valid[i-1];
                        r_data[i]  <= r_data[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cycles  <= '0;
            r_bubble_count  <= '0;
            r_retired_count <= '0;
        end else if (counter_clear) begin
            r_stall_cycles  <= '0;
            r_bubble_count  <= '0;
            r_retired_count <= '0;
        end else begin
            if (w_hold[0]) r_stall_cycles  <= sat_inc(r_stall_cycles);
            if (w_bubble)  r_bubble_count  <= sat_inc(r_bubble_count);
            if (w_retire)  r_retired_count <= sat_inc(r_retired_count);
        end
    end

    always_comb begin
        slot_data = '0;
        for (int i = 0; i < STAGES; i++) begin
            slot_data[i*DATA_WIDTH +: DATA_WIDTH] = r_data[i];
        end
    end

    assign in_ready      = !w_hold[0];
    assign out_valid     = r_valid[STAGES-1];
    assign out_data      = r_data[STAGES-1];
    assign slot_valid    = r_valid;
    assign stall_cycles  = r_stall_cycles;
    assign bubble_count  = r_bubble_count;
    assign retired_count = r_retired_count;

endmodule

// File: doc/pipeline_buffer_chain.md
Name: pipeline_buffer_chain

Overview:
Parametrised chain of inter-stage pipeline registers for the next-generation core. It replaces the fixed per-stage buffers with one block of STAGES slots carrying a DATA_WIDTH payload, each slot with a valid bit. Adds behaviour the fixed buffers lack:
- stall propagation with bubble insertion
- per-slot flush
- slot snoop outputs for forwarding
- saturating performance counters

Parameters:
DATA_WIDTH, 32, payload width per slot
STAGES, 4, number of slots (>=1); slot 0 is fed by in_data, slot STAGES-1 drives out_data
BUBBLE_VALUE, 0, payload loaded into a slot on bubble, flush or reset
COUNTER_WIDTH, 32, width of each performance counter

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low
in_valid  in  1  producer has a payload
in_data  in  DATA_WIDTH  producer payload
in_ready  out  1  slot 0 will load this cycle; equals !hold[0]
stall_request  in  STAGES  bit i: consumer of slot i cannot advance
flush  in  STAGES  bit i: invalidate slot i at the next edge
counter_clear  in  1  synchronous clear of all counters
out_valid  out  1  valid bit of slot STAGES-1
out_data  out  DATA_WIDTH  payload of slot STAGES-1
slot_valid  out  STAGES  valid bits of all slots, registered
slot_data  out  STAGES*DATA_WIDTH  flat payloads; slot i at [i*DATA_WIDTH +: DATA_WIDTH]
stall_cycles  out  COUNTER_WIDTH  cycles with hold[0]=1
bubble_count  out  COUNTER_WIDTH  cycles in which a bubble was inserted
retired_count  out  COUNTER_WIDTH  payloads leaving slot STAGES-1

Behaviour:
- Reset (reset=0, asynchronous):
  - all slot valid bits are 0
  - all slot payloads are BUBBLE_VALUE
  - all counters are 0
  - in_ready follows combinationally from stall_request
  - release is sampled at the first rising edge with reset=1.
- Hold vector: hold[i] = OR of stall_request[j] for all j >= i. A stall in a later slot therefore freezes all earlier slots. hold is always a prefix 0..m.
- Per-slot next state at each rising edge, first matching rule wins:
  1. flush[i]: valid=0, payload=BUBBLE_VALUE. Flush wins over hold.
  2. hold[i]: keep valid and payload.
  3. i>0 and hold[i-1]: insert a bubble (valid=0, payload=BUBBLE_VALUE).
  4. Otherwise advance. Slot 0 loads valid=in_valid, payload=in_data. Slot i>0 loads slot i-1.
- Input handshake:
  - A payload is accepted when in_valid && in_ready.
  - When in_ready=0, the producer holds its payload; in_data is ignored.
  - in_valid=0 with in_ready=1 loads an invalid slot 0 with payload = in_data (don't-care).
- Latency: exactly STAGES edges from acceptance to out_valid=1 when no stall occurs. Throughput is 1 per cycle.
- Retirement: retire = out_valid && !hold[STAGES-1].
- Snoop: slot_valid and slot_data are registered and reflect current slot contents. Consumers qualify slot_data with slot_valid.
- Counters, each updated per edge:
  - counter_clear=1 sets all counters to 0; clear wins over a simultaneous increment.
  - stall_cycles +1 when hold[0].
  - bubble_count +1 when rule 3 applied to any slot (at most one slot per cycle). A bubble inserted into a slot that is also flushed does not count.
  - retired_count +1 on retire.
  - All counters saturate at 2^COUNTER_WIDTH-1 and never wrap.
- STAGES=1: slot 0 is the output slot; rule 3 never applies; bubble_count stays 0.
- Flushing a slot does not affect hold; a flushed slot still stalls upstream if its stall_request is set.

Test Plan:
1. STAGES=4; accept 0x11, 0x22, 0x33 on consecutive cycles, no stalls -> out_data 0x11/0x22/0x33 with out_valid=1 on edges 4, 5, 6 after the first acceptance; then retired_count=3, stall_cycles=0.
2. Full pipeline holding A,B,C,D in slots 0..3; stall_request=4'b0010 for 2 cycles -> slots 0–1 frozen, in_ready=0; slot 2 valid=0 with payload 0 for those edges; D, then C, retire; stall_cycles=2, bubble_count=2.
3. Same edge: flush=4'b0100 and stall_request=4'b1000 -> slot 2 valid=0 with payload 0; slot 3 unchanged; slots 0–1 held; bubble_count unchanged.
4. Reset driven low mid-stream, between clock edges -> slot_valid=0 and all counters 0 immediately, without waiting for an edge; after release, the first accepted payload appears at out_data after 4 edges.
5. COUNTER_WIDTH=4; stall_request[0]=1 for 20 cycles -> stall_cycles reaches 15 and stays at 15.
6. counter_clear=1 on an edge where retire=1 and hold[0]=1 -> all counters read 0 afterwards; on the next unstalled retiring edge, retired_count=1.
